// File: rtl/spi_avl_slave_bridge.sv
// spi_avl_slave_bridge
//   SPI mode-0 responder that turns fixed command/address/data frames from the
//   SAM D21 into single-word Avalon-MM master transactions on the system bus.
//   Frame: byte 0 command (0x01 write, 0x02 read), bytes 1-2 word address
//   (high byte first), then four data bytes LSB first (reads insert one dummy
//   byte first). SCK/CS_n/MOSI are oversampled in the iCLK domain.
//
//   Optional build macro SPI_AVL_BRIDGE_AUTOINC_EN: bursts continue past the
//   first word at address+1 (writes every 4 bytes, reads prefetched).
//
// Ports
//   iCLK, iRESETn        system clock, asynchronous active-low reset
//   iSPI_SCK/CS_n/MOSI   SPI inputs from the master
//   oSPI_MISO(_OE)       SPI slave data and pad enable
//   oAVL_*/iAVL_*        Avalon-MM master port (word address)
//   oERR                 one-cycle pulse: unknown command or late read data
module spi_avl_slave_bridge #(
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              iCLK,
   input  logic              iRESETn,
   input  logic              iSPI_SCK,
   input  logic              iSPI_CS_n,
   input  logic              iSPI_MOSI,
   output logic              oSPI_MISO,
   output logic              oSPI_MISO_OE,
   output logic [ADDR_W-1:0] oAVL_ADDRESS,
   output logic              oAVL_READ,
   output logic              oAVL_WRITE,
   output logic [31:0]       oAVL_WRITE_DATA,
   input  logic [31:0]       iAVL_READ_DATA,
   input  logic              iAVL_WAIT_REQUEST,
   input  logic              iAVL_READ_DATAVALID,
   output logic              oERR
);

`ifdef SPI_AVL_BRIDGE_AUTOINC_EN
   localparam bit AutoInc = 1'b1;
`else
   localparam bit AutoInc = 1'b0;
`endif

   typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDUMMY, RDATA, IGNORE} stateT;

   logic [SYNC_STAGES-1:0] sckSync, csSync, mosiSync;
   logic                   sckPrev, csPrev;
   logic                   sckS, csS, mosiS;
   logic                   sckRise, sckFall, csFall, byteDone, loadPt, rdLoad, lateNow, dropDv;

   stateT             state;
   logic [2:0]        bitCnt;
   logic [1:0]        dataCnt;
   logic              addrLo, isRead;
   logic [7:0]        shiftIn, rxByte, addrHi, misoShift;
   logic [15:0]       addrFull;
   logic [ADDR_W-1:0] curAddr, newAddr, pendAddr, goAddr;
   logic [31:0]       wData, newWrData, pendData, goData, rdData, rdWord, rdShifted, selWord;
   logic              rdHave, rdWait, rdDrop;
   logic              newRd, newWr, pendRd, pendWr, havePend, goRd, goWr, busIdle;

   always_ff @(posedge iCLK or negedge iRESETn) begin
      if (!iRESETn) begin
         sckSync  <= '0;
         csSync   <= '1;
         mosiSync <= '0;
         sckPrev  <= 1'b0;
         csPrev   <= 1'b1;
      end else begin
         sckSync  <= {sckSync[SYNC_STAGES-2:0], iSPI_SCK};
         csSync   <= {csSync[SYNC_STAGES-2:0], iSPI_CS_n};
         mosiSync <= {mosiSync[SYNC_STAGES-2:0], iSPI_MOSI};
         sckPrev  <= sckS;
         csPrev   <= csS;
      end
   end

   always_comb begin
      sckS      = sckSync[SYNC_STAGES-1];
      csS       = csSync[SYNC_STAGES-1];
      mosiS     = mosiSync[SYNC_STAGES-1];
      sckRise   = sckS & ~sckPrev;
      sckFall   = ~sckS & sckPrev;
      csFall    = ~csS & csPrev;
      rxByte    = {shiftIn[6:0], mosiS};
      addrFull  = {addrHi, rxByte};
      byteDone  = ~csS && sckRise && (bitCnt == 3'd7);
      // bitCnt has wrapped to 0 after the 8th rise, so a fall there is the
      // 8th falling edge: the point where the next byte's MISO is loaded
      loadPt    = ~csS && sckFall && (bitCnt == 3'd0) && (state != IDLE);
      rdLoad    = loadPt && (state == RDATA) && (dataCnt == 2'd0);
      lateNow   = rdLoad && !rdHave;
      dropDv    = rdDrop || lateNow;
      selWord   = rdHave ? rdData : '1;
      rdShifted = rdWord >> {dataCnt, 3'b000};
      newWrData = {rxByte, wData[31:8]};
      newWr     = byteDone && (state == WDATA) && (dataCnt == 2'd3);
      newRd     = (byteDone && (state == ADDR) && addrLo && isRead) || (AutoInc && rdLoad);
      newAddr   = (state == ADDR) ? addrFull[ADDR_W-1:0] : curAddr;
      busIdle   = !oAVL_READ && !oAVL_WRITE;
      havePend  = pendRd || pendWr;
      goRd      = havePend ? pendRd : newRd;
      goWr      = havePend ? pendWr : newWr;
      goAddr    = havePend ? pendAddr : newAddr;
      goData    = havePend ? pendData : newWrData;
   end

   assign oSPI_MISO = misoShift[7];

   always_ff @(posedge iCLK or negedge iRESETn) begin
      if (!iRESETn) begin
         state           <= IDLE;
         bitCnt          <= '0;
         dataCnt         <= '0;
         addrLo          <= 1'b0;
         isRead          <= 1'b0;
         shiftIn         <= '0;
         addrHi          <= '0;
         misoShift       <= '0;
         curAddr         <= '0;
         wData           <= '0;
         rdData          <= '0;
         rdWord          <= '0;
         rdHave          <= 1'b0;
         rdWait          <= 1'b0;
         rdDrop          <= 1'b0;
         pendRd          <= 1'b0;
         pendWr          <= 1'b0;
         pendAddr        <= '0;
         pendData        <= '0;
         oSPI_MISO_OE    <= 1'b0;
         oAVL_ADDRESS    <= '0;
         oAVL_READ       <= 1'b0;
         oAVL_WRITE      <= 1'b0;
         oAVL_WRITE_DATA <= '0;
         oERR            <= 1'b0;
      end else begin
         oERR         <= 1'b0;
         oSPI_MISO_OE <= ~csS;

         if (csS) begin
            state     <= IDLE;
            misoShift <= '0;
         end else if (csFall) begin
            state     <= CMD;
            bitCnt    <= '0;
            dataCnt   <= '0;
            addrLo    <= 1'b0;
            misoShift <= '0;
         end else begin
            if (sckRise) begin
               shiftIn <= rxByte;
               bitCnt  <= bitCnt + 3'd1;
               if (bitCnt == 3'd7) begin
                  case (state)
                     CMD: begin
                        if (rxByte == 8'h01 || rxByte == 8'h02) begin
                           isRead <= (rxByte == 8'h02);
                           state  <= ADDR;
                        end else begin
                           state <= IGNORE;
                           oERR  <= 1'b1;
                        end
                     end
                     ADDR: begin
                        if (!addrLo) begin
                           addrHi <= rxByte;
                           addrLo <= 1'b1;
                        end else begin
                           // a read is issued right here, so the next word
                           // (only used by bursts) is already address+1
                           curAddr <= isRead ? addrFull[ADDR_W-1:0] + 1'b1 : addrFull[ADDR_W-1:0];
                           state   <= isRead ? RDUMMY : WDATA;
                           dataCnt <= '0;
                        end
                     end
                     WDATA: begin
                        wData   <= newWrData;
                        dataCnt <= dataCnt + 2'd1;
                        if (dataCnt == 2'd3) begin
                           if (AutoInc) curAddr <= curAddr + 1'b1;
                           else         state   <= IGNORE;
                        end
                     end
                     RDUMMY: begin
                        state   <= RDATA;
                        dataCnt <= '0;
                     end
                     RDATA: begin
                        dataCnt <= dataCnt + 2'd1;
                        if (dataCnt == 2'd3 && !AutoInc) state <= IGNORE;
                     end
                     default: ;
                  endcase
               end
            end
            if (sckFall) begin
               if (bitCnt != 3'd0) begin
                  misoShift <= {misoShift[6:0], 1'b0};
               end else if (state == RDATA) begin
                  if (dataCnt == 2'd0) begin
                     misoShift <= selWord[7:0];
                     rdWord    <= selWord;
                     rdHave    <= 1'b0;
                     if (!rdHave) begin
                        oERR <= 1'b1;
                        if (rdWait && !iAVL_READ_DATAVALID) rdDrop <= 1'b1;
                     end
                     if (AutoInc) curAddr <= curAddr + 1'b1;
                  end else begin
                     misoShift <= rdShifted[7:0];
                  end
               end else begin
                  misoShift <= '0;
               end
            end
         end

         if (iAVL_READ_DATAVALID) begin
            rdWait <= 1'b0;
            if (dropDv) begin
               rdDrop <= 1'b0;
            end else begin
               rdData <= iAVL_READ_DATA;
               rdHave <= 1'b1;
            end
         end

         // A command on the bus always finishes; new requests queue behind it
         if ((oAVL_READ || oAVL_WRITE) && !iAVL_WAIT_REQUEST) begin
            oAVL_READ  <= 1'b0;
            oAVL_WRITE <= 1'b0;
         end
         if (busIdle && (goRd || goWr)) begin
            oAVL_ADDRESS <= goAddr;
            oAVL_READ    <= goRd;
            oAVL_WRITE   <= goWr;
            if (goWr) oAVL_WRITE_DATA <= goData;
            if (goRd) begin
               rdWait <= 1'b1;
               rdDrop <= 1'b0;
               rdHave <= 1'b0;
            end
            if (havePend) begin
               pendRd   <= newRd;
               pendWr   <= newWr;
               pendAddr <= newAddr;
               pendData <= newWrData;
            end
         end else if (newRd || newWr) begin
            pendRd   <= newRd;
            pendWr   <= newWr;
            pendAddr <= newAddr;
            pendData <= newWrData;
         end
      end
   end

endmodule
